// File: rtl/ysyx_23060075_lsu_axil_master_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060075_lsu_axil_master_pkg
// Shared definitions for the AXI4-Lite bus bridges of the core: ISA data
// width, AXI response codes and the LSU bridge FSM state encoding. Kept in
// one place so the IFU fetch bridge can reuse the same codes.
// ---------------------------------------------------------------------------
package ysyx_23060075_lsu_axil_master_pkg;

  // ISA register / bus width
  localparam int XLEN = 32;

  // AXI xRESP codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Bridge FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_RESP    = 3'd5
  } lsu_axil_state_e;

  // Anything other than OKAY is reported to the LSU as a bus error.
  function automatic logic axi_resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_23060075_lsu_axil_master.sv
// ---------------------------------------------------------------------------
// ysyx_23060075_lsu_axil_master
// Converts one LSU data-memory request into one AXI4-Lite transaction and
// returns read data / error status over a valid/ready response handshake.
// A watchdog turns a hung handshake into an error response.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           LSU request handshake (ready only in IDLE)
//   req_addr/wdata/mask/r_en/w_en request payload, sampled at acceptance
//   resp_valid/resp_ready         LSU response handshake
//   resp_rdata/resp_err           raw read data (0 for writes) and error flag
//   ar*/r*/aw*/w*/b*              AXI4-Lite master channels
// ---------------------------------------------------------------------------
module ysyx_23060075_lsu_axil_master
  import ysyx_23060075_lsu_axil_master_pkg::*;
#(
  parameter int ADDR_WIDTH = XLEN,
  parameter int DATA_WIDTH = XLEN,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  // LSU request
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_mask,
  input  logic                    req_r_en,
  input  logic                    req_w_en,
  // LSU response
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  // AXI-Lite AR
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  // AXI-Lite R
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready,
  // AXI-Lite AW
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  // AXI-Lite W
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  // AXI-Lite B
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int WD_WIDTH   = $clog2(TIMEOUT + 1);

  lsu_axil_state_e         r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_WIDTH-1:0]   r_mask;
  logic [WD_WIDTH-1:0]     r_wd_cnt;
  logic                    r_aw_done;
  logic                    r_w_done;

  logic                    r_req_ready;
  logic                    r_resp_valid;
  logic [DATA_WIDTH-1:0]   r_resp_rdata;
  logic                    r_resp_err;
  logic                    r_arvalid;
  logic                    r_rready;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_bready;

  logic                    w_aw_done_next;
  logic                    w_w_done_next;
  logic                    w_busy;
  logic                    w_progress;
  logic                    w_wd_expire;

  // AW and W complete independently; these include a handshake this cycle.
  assign w_aw_done_next = r_aw_done | (r_awvalid & awready);
  assign w_w_done_next  = r_w_done  | (r_wvalid  & wready);

  // The counter holds the number of cycles already spent in the current bus
  // state, so the cycle in which it equals TIMEOUT-1 is the TIMEOUT-th one.
  assign w_wd_expire = (r_wd_cnt == WD_WIDTH'(TIMEOUT - 1));

  always_comb begin
    w_busy     = 1'b0;
    w_progress = 1'b0;
    case (r_state)
      ST_RD_ADDR: begin w_busy = 1'b1; w_progress = r_arvalid & arready; end
      ST_RD_DATA: begin w_busy = 1'b1; w_progress = rvalid; end
      ST_WR_REQ:  begin w_busy = 1'b1; w_progress = w_aw_done_next & w_w_done_next; end
      ST_WR_RESP: begin w_busy = 1'b1; w_progress = bvalid; end
      default:    begin w_busy = 1'b0; w_progress = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mask       <= '0;
      r_wd_cnt     <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
    end else if (w_busy && w_wd_expire && !w_progress) begin
      // Hung handshake: drop every channel and report an error. A slave
      // response arriving afterwards is not observed.
      r_state      <= ST_RESP;
      r_wd_cnt     <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_resp_valid <= 1'b1;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_mask      <= req_mask;
            r_wd_cnt    <= '0;
            r_req_ready <= 1'b0;
            if (req_w_en) begin
              // Write takes priority when both enables are set.
              r_state   <= ST_WR_REQ;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else if (req_r_en) begin
              r_state   <= ST_RD_ADDR;
              r_arvalid <= 1'b1;
            end else begin
              // No-op request: answer immediately without bus traffic.
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
              r_resp_err   <= 1'b0;
            end
          end
        end

        ST_RD_ADDR: begin
          if (w_progress) begin
            r_state   <= ST_RD_DATA;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_wd_cnt  <= '0;
          end else begin
            r_wd_cnt <= r_wd_cnt + WD_WIDTH'(1);
          end
        end

        ST_RD_DATA: begin
          if (w_progress) begin
            r_state      <= ST_RESP;
            r_rready     <= 1'b0;
            r_wd_cnt     <= '0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= rdata;
            r_resp_err   <= axi_resp_is_err(rresp);
          end else begin
            r_wd_cnt <= r_wd_cnt + WD_WIDTH'(1);
          end
        end

        ST_WR_REQ: begin
          if (w_progress) begin
            r_state   <= ST_WR_RESP;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_wd_cnt  <= '0;
          end else begin
            // Each valid drops on its own handshake, never before it.
            r_aw_done <= w_aw_done_next;
            r_w_done  <= w_w_done_next;
            r_awvalid <= ~w_aw_done_next;
            r_wvalid  <= ~w_w_done_next;
            r_wd_cnt  <= r_wd_cnt + WD_WIDTH'(1);
          end
        end

        ST_WR_RESP: begin
          if (w_progress) begin
            r_state      <= ST_RESP;
            r_bready     <= 1'b0;
            r_wd_cnt     <= '0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= '0;
            r_resp_err   <= axi_resp_is_err(bresp);
          end else begin
            r_wd_cnt <= r_wd_cnt + WD_WIDTH'(1);
          end
        end

        ST_RESP: begin
          // Response data is held untouched until the LSU takes it.
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign araddr     = r_addr;
  assign arvalid    = r_arvalid;
  assign rready     = r_rready;
  assign awaddr     = r_addr;
  assign awvalid    = r_awvalid;
  assign wdata      = r_wdata;
  assign wstrb      = r_mask;
  assign wvalid     = r_wvalid;
  assign bready     = r_bready;

endmodule

// File: tb/tb_ysyx_23060075_lsu_axil_master.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060075_lsu_axil_master
// Directed bench for the LSU AXI-Lite bridge. Inputs change and outputs are
// sampled on the falling edge; the slave side is driven cycle by cycle.
// ---------------------------------------------------------------------------
module tb_ysyx_23060075_lsu_axil_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_mask = '0;
  logic        req_r_en = 1'b0;
  logic        req_w_en = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  ysyx_23060075_lsu_axil_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(15)
  ) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_mask(req_mask), .req_r_en(req_r_en),
    .req_w_en(req_w_en),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a request; it is accepted at the next rising edge (cycle N).
  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic r, input logic w);
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_mask = m;
    req_r_en = r; req_w_en = w;
  endtask

  task automatic drop_req();
    req_valid = 1'b0; req_r_en = 1'b0; req_w_en = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1;
    repeat (3) step();
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_rdata", resp_rdata, 0);
    check_eq("rst_resp_err", resp_err, 0);
    check_eq("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
    rst = 1'b0;
    step();
    $display("reset done");

    // ---------------- zero-wait read ----------------
    arready = 1'b1;
    issue(32'h8000_0004, 32'h0, 4'h0, 1'b1, 1'b0);
    step();                                   // N+1
    drop_req();
    check_eq("rd_arvalid_n1", arvalid, 1);
    check_eq("rd_araddr", araddr, 32'h8000_0004);
    check_eq("rd_req_ready_n1", req_ready, 0);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
    step();                                   // N+2
    check_eq("rd_arvalid_n2", arvalid, 0);
    check_eq("rd_rready_n2", rready, 1);
    check_eq("rd_resp_valid_n2", resp_valid, 0);
    step();                                   // N+3
    rvalid = 1'b0; arready = 1'b0;
    check_eq("rd_resp_valid_n3", resp_valid, 1);
    check_eq("rd_rdata", resp_rdata, 32'hDEAD_BEEF);
    check_eq("rd_err", resp_err, 0);
    check_eq("rd_rready_n3", rready, 0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check_eq("rd_back_idle", {req_ready, resp_valid}, 2'b10);
    $display("read 0x80000004 -> 0x%08h err=%0d", 32'hDEAD_BEEF, 0);

    // ---------------- no-op ----------------
    issue(32'h8000_0008, 32'h0, 4'h0, 1'b0, 1'b0);
    step();                                   // N+1
    drop_req();
    check_eq("nop_resp_valid", resp_valid, 1);
    check_eq("nop_rdata", resp_rdata, 0);
    check_eq("nop_err", resp_err, 0);
    check_eq("nop_no_axi", {arvalid, awvalid, wvalid, rready, bready}, 0);
    check_eq("nop_req_ready", req_ready, 0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check_eq("nop_back_idle", req_ready, 1);
    $display("no-op -> resp at N+1");

    // ---------------- write, AW two cycles ahead of W ----------------
    awready = 1'b1; wready = 1'b0;
    issue(32'h8000_0010, 32'h0000_00AB, 4'b0001, 1'b0, 1'b1);
    step();                                   // N+1: AW fires at next edge
    drop_req();
    check_eq("wr_awvalid_n1", awvalid, 1);
    check_eq("wr_wvalid_n1", wvalid, 1);
    check_eq("wr_awaddr", awaddr, 32'h8000_0010);
    check_eq("wr_wdata", wdata, 32'h0000_00AB);
    check_eq("wr_wstrb", wstrb, 4'b0001);
    step();                                   // N+2
    awready = 1'b0;
    check_eq("wr_awvalid_n2", awvalid, 0);
    check_eq("wr_wvalid_n2", wvalid, 1);
    step();                                   // N+3: W fires at next edge
    check_eq("wr_wvalid_n3", wvalid, 1);
    check_eq("wr_bready_n3", bready, 0);
    wready = 1'b1;
    step();                                   // N+4
    wready = 1'b0;
    check_eq("wr_wvalid_n4", wvalid, 0);
    check_eq("wr_bready_n4", bready, 1);
    check_eq("wr_resp_valid_n4", resp_valid, 0);
    bvalid = 1'b1; bresp = 2'b00;
    step();                                   // N+5
    bvalid = 1'b0;
    check_eq("wr_resp_valid", resp_valid, 1);
    check_eq("wr_err", resp_err, 0);
    check_eq("wr_rdata", resp_rdata, 0);
    check_eq("wr_bready_n5", bready, 0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check_eq("wr_back_idle", req_ready, 1);
    $display("write 0x80000010 <= 0x000000ab strb=0001 err=0");

    // ---------------- r_en and w_en together: write only, DECERR ----------
    awready = 1'b1; wready = 1'b1;
    issue(32'h8000_0030, 32'h55AA_55AA, 4'hF, 1'b1, 1'b1);
    step();                                   // N+1
    drop_req();
    check_eq("both_arvalid_n1", arvalid, 0);
    check_eq("both_aw_w_n1", {awvalid, wvalid}, 2'b11);
    step();                                   // N+2
    awready = 1'b0; wready = 1'b0;
    check_eq("both_arvalid_n2", arvalid, 0);
    check_eq("both_bready", bready, 1);
    check_eq("both_aw_w_n2", {awvalid, wvalid}, 2'b00);
    bvalid = 1'b1; bresp = 2'b11;
    step();                                   // N+3
    bvalid = 1'b0; bresp = 2'b00;
    check_eq("both_resp_valid", resp_valid, 1);
    check_eq("both_err", resp_err, 1);
    check_eq("both_arvalid_n3", arvalid, 0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    $display("r_en+w_en 0x80000030 -> write only, bresp=DECERR err=1");

    // ---------------- read SLVERR, response back-pressured ----------------
    arready = 1'b1;
    issue(32'h8000_0020, 32'h0, 4'h0, 1'b1, 1'b0);
    step();                                   // N+1
    drop_req();
    rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b10;
    step();                                   // N+2
    check_eq("slv_rready", rready, 1);
    step();                                   // N+3
    rvalid = 1'b0; rdata = 32'hFFFF_FFFF; rresp = 2'b00; arready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("slv_hold_valid", resp_valid, 1);
      check_eq("slv_hold_rdata", resp_rdata, 32'h1234_5678);
      check_eq("slv_hold_err", resp_err, 1);
      check_eq("slv_hold_req_ready", req_ready, 0);
      step();
    end
    check_eq("slv_still_valid", resp_valid, 1);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check_eq("slv_back_idle", {req_ready, resp_valid}, 2'b10);
    $display("read 0x80000020 rresp=SLVERR held 5 cycles err=1");

    // ---------------- watchdog: arready never comes ----------------
    arready = 1'b0;
    issue(32'h8000_0040, 32'h0, 4'h0, 1'b1, 1'b0);
    step();                                   // N+1
    drop_req();
    for (int k = 1; k <= 15; k++) begin
      check_eq("to_arvalid_held", arvalid, 1);
      check_eq("to_no_resp", resp_valid, 0);
      step();
    end                                       // now at N+16
    check_eq("to_resp_valid", resp_valid, 1);
    check_eq("to_err", resp_err, 1);
    check_eq("to_rdata", resp_rdata, 0);
    check_eq("to_arvalid_dropped", arvalid, 0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check_eq("to_back_idle", req_ready, 1);
    $display("read 0x80000040 no arready -> timeout err=1 after 15 cycles");

    // ---------------- reset during WR_RESP ----------------
    awready = 1'b1; wready = 1'b1;
    issue(32'h8000_0050, 32'h0000_1111, 4'hF, 1'b0, 1'b1);
    step();                                   // N+1
    drop_req();
    step();                                   // N+2: WR_RESP
    awready = 1'b0; wready = 1'b0;
    check_eq("rstw_bready", bready, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rstw_axi_idle", {arvalid, rready, awvalid, wvalid, bready}, 0);
    check_eq("rstw_req_ready", req_ready, 1);
    check_eq("rstw_resp_valid", resp_valid, 0);
    $display("reset during WR_RESP -> bus idle, req_ready=1");

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060075_lsu_axil_master.md
Name: ysyx_23060075_lsu_axil_master

Overview:
Memory-side bus master that consumes the LSU's data-memory request (addr, wdata, byte mask, r_en, w_en) and converts it into one AXI4-Lite transaction. It returns read data and status through a valid/ready response handshake. It replaces the zero-latency data-memory port so the LSU stage can tolerate variable memory latency. A watchdog converts a hung transaction into an error response.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; byte-strobe width is DATA_WIDTH/8
TIMEOUT, 1023, maximum cycles waiting on any AXI handshake before an error response is forced (counter width clog2(TIMEOUT+1))

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  LSU request valid
req_ready  out  1  bridge idle and able to accept
req_addr  in  ADDR_WIDTH  byte address, already aligned by LSU
req_wdata  in  DATA_WIDTH  store data, already lane-shifted by LSU
req_mask  in  DATA_WIDTH/8  byte strobes
req_r_en  in  1  read request
req_w_en  in  1  write request
resp_valid  out  1  response valid
resp_ready  in  1  LSU accepts response
resp_rdata  out  DATA_WIDTH  read data (0 for writes/no-op)
resp_err  out  1  bus error (xRESP!=OKAY) or timeout
araddr/arvalid/arready  out/out/in  ADDR_WIDTH/1/1  AXI-Lite AR channel
rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/2/1/1  AXI-Lite R channel
awaddr/awvalid/awready  out/out/in  ADDR_WIDTH/1/1  AXI-Lite AW channel
wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  AXI-Lite W channel
bresp/bvalid/bready  in/in/out  2/1/1  AXI-Lite B channel

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; arvalid, rready, awvalid, wvalid, bready all 0; watchdog=0. Reset mid-transaction abandons it next cycle (the slave is reset by the same rst).
- req_ready = (state==IDLE). Request accepted on req_valid&&req_ready; addr/wdata/mask registered at acceptance. Inputs are ignored in every other state.
- Decode at acceptance:
  - w_en=1 -> WR_REQ (w_en wins if both set).
  - r_en=1 only -> RD_ADDR.
  - neither -> RESP directly with rdata=0, err=0, no bus traffic.
- RD_ADDR: arvalid=1, araddr=registered addr. On arready go to RD_DATA, arvalid drops the following cycle.
- RD_DATA: rready=1. On rvalid capture rdata into resp_rdata, set resp_err=(rresp!=0), go to RESP.
- WR_REQ: awvalid and wvalid rise together. Each drops independently after its own handshake, tracked by aw_done/w_done flags. When both are done (same or different cycles) go to WR_RESP.
- WR_RESP: bready=1. On bvalid set resp_err=(bresp!=0), resp_rdata=0, go to RESP.
- RESP: resp_valid=1, held with stable data until resp_ready; then go to IDLE. resp_valid=1 and req_ready=1 never occur together.
- AXI rule: a master valid, once asserted, is never withdrawn before its ready.
- Minimum latency with zero-wait slave: acceptance cycle N; arvalid at N+1; rready/rvalid at N+2; resp_valid at N+3. A no-op gives resp_valid at N+1.
- Watchdog:
  - Clears on every state change; increments each cycle in RD_ADDR/RD_DATA/WR_REQ/WR_RESP.
  - On reaching TIMEOUT: go to RESP with resp_err=1, rdata=0, and deassert all AXI valids/readies.
  - Accepted consequence: a later late slave response is ignored. Integration must avoid this, since it violates AXI; the watchdog is a debug aid only.
- Response lanes: rdata is returned raw. Sign/zero extension and lane selection remain in the LSU core.

Decomposition:
- Shared header: AXI response codes (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11) and the FSM state encoding localparams. These sit alongside the existing ISA width macros so future IFU fetch bridges reuse them.
- No sub-module needed. An optional sub-module ysyx_23060075_axil_watchdog (counter + timeout flag) can be factored out for reuse by the IFU bridge.

Test Plan:
- Read, zero-wait slave: addr 0x80000004, slave returns 0xDEADBEEF -> arvalid at N+1, resp_valid at N+3, resp_rdata=0xDEADBEEF, resp_err=0.
- Write, AW ready 2 cycles before W: addr 0x80000010, wdata 0x000000AB, mask 4'b0001 -> wstrb=0001; awvalid drops after its handshake, wvalid held until wready; resp_valid after bvalid with err=0.
- Read with rresp=SLVERR and resp_ready held low 5 cycles -> resp_valid, rdata and err=1 stable all 5 cycles; req_ready=0 throughout.
- Both r_en and w_en set -> write transaction only, no arvalid. Neither set -> resp_valid at N+1, no AXI valids asserted.
- Slave never asserts arready, TIMEOUT=15 -> resp_err=1 after 15 cycles in RD_ADDR, then arvalid=0 and return to IDLE.
- rst asserted during WR_RESP -> next cycle all valids/readies 0, req_ready=1, resp_valid=0.
